// File: rtl/mux41_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux41_scan_ctrl
//
// Purpose:
//    Sequencer that sits directly upstream of a 4:1 mux (MUX41). It scans
//    the channels enabled in a 4-bit mask in round-robin order and drives
//    the mux select lines for each one. After each select change it waits
//    DWELL cycles for the mux output to settle, then captures that output.
//    Each captured sample is tagged with its channel number and handed to
//    downstream logic over a valid/ready handshake.
//
// Parameters:
//    DW     data width of the mux output
//    DWELL  settle cycles between a select change and the capture (1..15)
//    CW     width of the dwell counter; must be able to hold DWELL
//
// Ports:
//    iclk    in   clock, rising edge
//    irst_n  in   asynchronous active-low reset
//    ien     in   scan enable
//    imask   in   [3:0] channel enable mask, bit k enables channel k
//    iz      in   [DW-1:0] mux output (MUX41 oz)
//    iready  in   downstream ready
//    ois1    out  select MSB (MUX41 is1)
//    ois0    out  select LSB (MUX41 is0)
//    odata   out  [DW-1:0] captured sample
//    ochan   out  [1:0] channel index of odata
//    ovalid  out  odata/ochan/olast valid
//    olast   out  sample is the last enabled channel of the current round
//    obusy   out  controller is not idle
// -----------------------------------------------------------------------------
module mux41_scan_ctrl #(
   parameter int DW    = 4,
   parameter int DWELL = 3,
   parameter int CW    = 4
) (
   input  logic          iclk,
   input  logic          irst_n,
   input  logic          ien,
   input  logic [3:0]    imask,
   input  logic [DW-1:0] iz,
   input  logic          iready,
   output logic          ois1,
   output logic          ois0,
   output logic [DW-1:0] odata,
   output logic [1:0]    ochan,
   output logic          ovalid,
   output logic          olast,
   output logic          obusy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   // Loading DWELL-1 makes the capture land exactly DWELL edges after the
   // select change, because the load itself happens on the select edge.
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

   state_t        state_q;
   logic [1:0]    ptr_q;
   logic [1:0]    sel_q;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] data_q;
   logic [1:0]    chan_q;
   logic          valid_q;
   logic          last_q;

   logic [1:0]    nxt_chan_d;
   logic          start_d;
   logic [3:0]    any_above;

   // Next channel: first enabled channel scanning ptr+1, ptr+2, ptr+3 and
   // finally ptr itself (offset 4 wraps to 0), so a lone enabled channel
   // is chosen again.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      nxt_chan_d = ptr_q;
      found      = 1'b0;
      idx        = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && imask[idx]) begin
            nxt_chan_d = idx;
            found      = 1'b1;
         end
      end
   end

   // any_above[p] is set when some channel numbered above p is enabled.
   // A capture from channel p is the last of its round when this is clear.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_above
         assign any_above[gi] = |(imask >> (gi + 1));
      end
   endgenerate

   assign start_d = ien && (imask != 4'b0000);

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd3;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
         data_q  <= '0;
         chan_q  <= 2'd0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_d) begin
                  ptr_q   <= nxt_chan_d;
                  sel_q   <= nxt_chan_d;
                  cnt_q   <= CNT_LOAD;
                  state_q <= SETTLE;
               end
            end

            SETTLE: begin
               if (!ien) begin
                  // Abort: nothing has been captured, so nothing is emitted.
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  data_q  <= iz;
                  chan_q  <= ptr_q;
                  valid_q <= 1'b1;
                  last_q  <= ~any_above[ptr_q];
                  state_q <= HOLD;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end

            HOLD: begin
               // Everything stays frozen until the sample is taken; the
               // next channel is selected on the very transfer edge so the
               // scan loses no cycle to the handshake.
               if (valid_q && iready) begin
                  valid_q <= 1'b0;
                  if (start_d) begin
                     ptr_q   <= nxt_chan_d;
                     sel_q   <= nxt_chan_d;
                     cnt_q   <= CNT_LOAD;
                     state_q <= SETTLE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ois1   = sel_q[1];
   assign ois0   = sel_q[0];
   assign odata  = data_q;
   assign ochan  = chan_q;
   assign ovalid = valid_q;
   assign olast  = last_q;
   assign obusy  = (state_q != IDLE);

endmodule

// File: doc/mux41_scan_ctrl.md
Name: mux41_scan_ctrl

Overview:
- Sequencing stage directly upstream of MUX41: drives its select lines is1/is0 and takes its output oz back in.
- Round-robin scan over the enabled channels of a 4-channel mask.
- Holds each select for a programmable settle time, then captures the mux output.
- Presents each captured sample, tagged with its channel number, to downstream logic over a valid/ready handshake.

Parameters:
DW, 4, data width of the mux output (matches MUX41 oz).
DWELL, 3, settle cycles between a select change and the capture; legal range 1..15.
CW, 4, width of the internal dwell counter; must hold DWELL.

Ports:
iclk  input  1  clock, rising-edge.
irst_n  input  1  asynchronous active-low reset.
ien  input  1  scan enable.
imask  input  4  channel enable mask; bit k enables channel k.
iz  input  DW  mux output; connects to MUX41 oz.
iready  input  1  downstream ready.
ois1  output  1  select MSB; connects to MUX41 is1.
ois0  output  1  select LSB; connects to MUX41 is0.
odata  output  DW  captured sample.
ochan  output  2  channel index of odata.
ovalid  output  1  odata/ochan/olast valid.
olast  output  1  sample is the last enabled channel of the current round.
obusy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, irst_n=0):
  - state=IDLE; ois1=ois0=0; odata=0; ochan=0; ovalid=0; olast=0; obusy=0.
  - Internal pointer=3, so the first selected channel is channel 0.
- Next-channel function: the first enabled channel found scanning from pointer+1 upward, modulo 4. If the pointer's own channel is the only one enabled, it is chosen again.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If ien=1 and imask!=0: select next channel, update pointer and {ois1,ois0}, load counter=DWELL-1, go SETTLE.
  - Otherwise stay; select lines keep their last value.
- SETTLE:
  - If ien=0: abort, go IDLE. No sample is produced; ovalid stays 0.
  - Else if counter=0: odata<=iz, ochan<=pointer, ovalid<=1, go HOLD.
    - olast<=1 when no imask bit above the pointer is set at this edge.
  - Else counter decrements.
  - iz is therefore sampled after the select has been stable for exactly DWELL cycles: the select changes at edge N, the capture and ovalid rise occur at edge N+DWELL.
- HOLD:
  - odata, ochan, olast and the select lines are frozen while ovalid=1 and iready=0.
  - Transfer occurs on a rising edge with ovalid=1 and iready=1.
  - On transfer, if ien=1 and imask!=0: ovalid<=0, select the next channel in the same edge, load counter, go SETTLE.
  - On transfer otherwise: ovalid<=0, go IDLE.
  - ien falling while in HOLD does not drop the pending sample; it completes, then IDLE.
- Steady-state throughput with iready=1: one sample per DWELL+1 cycles.
- imask is sampled only at channel-selection and capture edges. A mask change mid-SETTLE does not abort the current channel.
- Disabled channels are skipped with no dwell spent on them. imask=0 in IDLE keeps the FSM idle.
- obusy=1 in SETTLE and HOLD.
- Reset asserted mid-operation: immediate return to the reset values above; no partial sample is emitted.

Test Plan:
- Setup: MUX41 instantiated with ic0=4'h1, ic1=4'h2, ic2=4'h3, ic3=4'h4; oz→iz, ois1/ois0→is1/is0; DWELL=3.
- Full scan: ien=1, imask=4'b1111, iready=1 → samples (ochan,odata) = (0,1),(1,2),(2,3),(3,4),(0,1)…; ovalid pulses every 4 cycles; olast=1 only on ch3; first ovalid 3 cycles after select leaves IDLE.
- Sparse mask: imask=4'b1010 → samples alternate (1,2),(3,4); select never shows 00 or 10 after the first selection; olast=1 on ch3.
- Backpressure: iready=0 for 10 cycles after first ovalid → odata=1, ochan=0, select=00 held constant; on iready=1 the transfer occurs and ch1 is selected in the same edge.
- Abort/drain: ien→0 during SETTLE of ch2 → IDLE next edge, no ovalid. ien→0 during HOLD with iready=0 → sample held until iready=1, then IDLE, obusy=0.
- Reset mid-HOLD: irst_n low asynchronously between edges → ovalid, odata, select and obusy drop to 0 immediately. After release with ien=1, the first sample is ch0 (odata=1).
- Single channel: imask=4'b0100 → repeated (2,3) with olast=1 every sample; select stays 10.
